// File: rtl/my_fourbit_divider_if.sv
// Request/result bundle of the restoring divider. START/A/B come from the ULA control,
// Q/R/BUSY/DONE/DIV0 are returned by the divider.
interface my_fourbit_divider_if #(
  parameter int WIDTH = 4
);
  // START is only honoured while the divider is idle; A and B are captured in that same cycle.
  // DONE pulses for exactly one cycle, and Q/R/DIV0 are valid in that cycle.
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             BUSY;
  logic             DONE;
  logic             DIV0;

  modport master (
    output START, A, B,
    input  Q, R, BUSY, DONE, DIV0
  );

  modport slave (
    input  START, A, B,
    output Q, R, BUSY, DONE, DIV0
  );
endinterface

// File: rtl/my_fourbit_divider.sv
// Sequential unsigned restoring divider. It produces one quotient bit per clock.
// A zero divisor skips the iterations and is reported through DIV0.
module my_fourbit_divider #(
  parameter int WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  my_fourbit_divider_if.slave  bus,
  output logic [1:0]           state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH-1:0] sub;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  logic             start_ok;
  logic             start_zero;

  assign start_zero = bus.START && (bus.B == '0);
  assign start_ok   = bus.START && (bus.B != '0);
  assign state_dbg  = state;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // BUSY and DONE decode only the state register, so there is no path from the inputs to them.
  always_comb begin
    next_state = state;
    bus.BUSY   = 1'b0;
    bus.DONE   = 1'b0;
    case (state)
      IDLE: begin
        if (start_zero) begin
          next_state = FIN;
        end else if (start_ok) begin
          next_state = CALC;
        end
      end
      CALC: begin
        bus.BUSY = 1'b1;
        if (cnt == '0) begin
          next_state = FIN;
        end
      end
      FIN: begin
        bus.BUSY   = 1'b1;
        bus.DONE   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Trial subtraction. Its result is always below the divisor, so WIDTH bits are enough to hold it.
  always_comb begin
    t        = {rem, dividend[WIDTH-1]};
    ge       = (t >= {1'b0, divisor});
    sub      = t[WIDTH-1:0] - divisor;
    rem_next = ge ? sub : t[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ge};
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      bus.Q    <= '0;
      bus.R    <= '0;
      bus.DIV0 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_zero) begin
            bus.Q    <= '1;
            bus.R    <= bus.A;
            bus.DIV0 <= 1'b1;
          end else if (start_ok) begin
            dividend <= bus.A;
            divisor  <= bus.B;
            rem      <= '0;
            quo      <= '0;
            cnt      <= CW'(WIDTH - 1);
            bus.DIV0 <= 1'b0;
          end
        end
        CALC: begin
          dividend <= {dividend[WIDTH-2:0], 1'b0};
          rem      <= rem_next;
          quo      <= quo_next;
          cnt      <= cnt - 1'b1;
          // Q and R are written only once, on the final iteration.
          if (cnt == '0) begin
            bus.Q <= quo_next;
            bus.R <= rem_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_my_fourbit_divider.sv
// Directed bench for my_fourbit_divider. It covers reset, nominal divisions, divide-by-zero,
// START while busy, reset during an operation, and an exhaustive sweep of all operand pairs.
module tb_my_fourbit_divider;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         compared;
  int         mismatched;
  int         cyc;
  int         prev_done;
  bit         chk_gap;

  my_fourbit_divider_if #(.WIDTH(4)) bus ();

  my_fourbit_divider #(.WIDTH(4)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_q"},    32'(bus.Q),    32'h0);
    chk({tag, "_r"},    32'(bus.R),    32'h0);
    chk({tag, "_busy"}, 32'(bus.BUSY), 32'h0);
    chk({tag, "_done"}, 32'(bus.DONE), 32'h0);
    chk({tag, "_div0"}, 32'(bus.DIV0), 32'h0);
  endtask

  // Called at a negedge. START is taken at the next posedge (e0), and the task returns at the negedge after e0.
  task automatic launch(input logic [3:0] a, input logic [3:0] b);
    bus.START = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.START = 1'b0;
    bus.A     = 4'($urandom_range(0, 15));
    bus.B     = 4'($urandom_range(0, 15));
  endtask

  task automatic finish_op(input string tag, input int n0, input logic [3:0] eq,
                           input logic [3:0] er, input logic ed, input int lat);
    int n;
    n = n0;
    while (bus.DONE !== 1'b1 && n < 12) begin
      chk({tag, "_busy_run"}, 32'(bus.BUSY), 32'h1);
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    if (chk_gap && prev_done >= 0) chk({tag, "_gap"}, 32'(cyc - prev_done), 32'(lat + 1));
    prev_done = cyc;
    chk({tag, "_q"},    32'(bus.Q),    32'(eq));
    chk({tag, "_r"},    32'(bus.R),    32'(er));
    chk({tag, "_div0"}, 32'(bus.DIV0), 32'(ed));
    chk({tag, "_busy_done"}, 32'(bus.BUSY), 32'h1);
    @(negedge clk);
    chk({tag, "_done_low"}, 32'(bus.DONE), 32'h0);
    chk({tag, "_idle"},     32'(bus.BUSY), 32'h0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    prev_done  = -1;
    chk_gap    = 1'b0;
    rst_n      = 1'b0;
    bus.START  = 1'b1;
    bus.A      = 4'd5;
    bus.B      = 4'd0;

    repeat (2) @(negedge clk);
    chk_idle_zero("rst_held");
    rst_n     = 1'b1;
    bus.START = 1'b0;
    @(negedge clk);
    chk_idle_zero("rst_rel");

    launch(4'd13, 4'd3);
    finish_op("d13_3", 1, 4'd4, 4'd1, 1'b0, 5);
    launch(4'd15, 4'd1);
    finish_op("d15_1", 1, 4'd15, 4'd0, 1'b0, 5);
    launch(4'd2, 4'd7);
    finish_op("d2_7", 1, 4'd0, 4'd2, 1'b0, 5);

    launch(4'd5, 4'd0);
    finish_op("d5_0", 1, 4'hF, 4'd5, 1'b1, 1);
    repeat (4) begin
      @(negedge clk);
      chk("d5_0_hold_q",    32'(bus.Q),    32'hF);
      chk("d5_0_hold_r",    32'(bus.R),    32'h5);
      chk("d5_0_hold_div0", 32'(bus.DIV0), 32'h1);
    end
    // An accepted START clears DIV0 at once, but Q keeps its old value until FIN.
    launch(4'd15, 4'd1);
    chk("div0_clr",  32'(bus.DIV0), 32'h0);
    chk("q_no_early", 32'(bus.Q),   32'hF);
    finish_op("d15_1b", 1, 4'd15, 4'd0, 1'b0, 5);

    launch(4'd13, 4'd3);
    @(negedge clk);
    bus.START = 1'b1;
    bus.A     = 4'd9;
    bus.B     = 4'd2;
    @(negedge clk);
    bus.START = 1'b0;
    finish_op("busy_start", 3, 4'd4, 4'd1, 1'b0, 5);
    repeat (8) begin
      @(negedge clk);
      chk("busy_start_no_done", 32'(bus.DONE), 32'h0);
      chk("busy_start_q_hold",  32'(bus.Q),    32'h4);
    end

    launch(4'd13, 4'd3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_zero("mid_rst");
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("mid_rst_no_done", 32'(bus.DONE), 32'h0);
    end
    launch(4'd12, 4'd5);
    finish_op("d12_5", 1, 4'd2, 4'd2, 1'b0, 5);

    chk_gap   = 1'b1;
    prev_done = -1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        launch(4'(a), 4'(b));
        if (b == 0) finish_op("ex_div0", 1, 4'hF, 4'(a), 1'b1, 1);
        else        finish_op("ex", 1, 4'(a / b), 4'(a % b), 1'b0, 5);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
